// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and FSM state encoding for the single-precision multiplier
package fpu_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EMIN = -126;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MUL0, MUL1, NORM1, NORM2, ROUND, PACK, PUT_Z
  } state_t;
endpackage

// File: rtl/fpu_multiplier_no_handshake.sv
// fpu_multiplier_no_handshake: multi-cycle IEEE-754 single multiplier, strobe in / strobe out, RNE, denormals
module fpu_multiplier_no_handshake
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic [31:0] output_z,
  output logic        output_z_stb
);
  state_t state, next;
  logic start_q, start, sz, s, g, r, st;
  logic [31:0] a, b;
  logic [23:0] am, bm, m;
  logic signed [9:0] ae, be, e;
  logic [47:0] prod;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nan_case, special;
  assign start = input_a_stb & input_b_stb & ~start_q;
  assign a_nan = &a[30:23] & |a[22:0];
  assign b_nan = &b[30:23] & |b[22:0];
  assign a_inf = &a[30:23] & ~|a[22:0];
  assign b_inf = &b[30:23] & ~|b[22:0];
  assign a_zero = ~|a[30:0];
  assign b_zero = ~|b[30:0];
  assign sz = a[31] ^ b[31];
  assign nan_case = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign special = nan_case | a_inf | b_inf | a_zero | b_zero;
  // next-state: normalise states loop one bit per cycle until their condition clears
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? UNPACK : IDLE;
      UNPACK:  next = SPECIAL;
      SPECIAL: next = special ? PUT_Z : NORM_A;
      NORM_A:  next = am[23] ? NORM_B : NORM_A;
      NORM_B:  next = bm[23] ? MUL0 : NORM_B;
      MUL0:    next = MUL1;
      MUL1:    next = NORM1;
      NORM1:   next = (m[23] || e <= EMIN) ? NORM2 : NORM1;
      NORM2:   next = (e < EMIN) ? NORM2 : ROUND;
      ROUND:   next = PACK;
      PACK:    next = PUT_Z;
      default: next = IDLE;
    endcase
  end
  // state register and datapath; output_z/stb are written on the edge entering PUT_Z
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      output_z <= '0;
      output_z_stb <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state <= next;
      start_q <= input_a_stb & input_b_stb;
      output_z_stb <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a <= input_a;
          b <= input_b;
        end
        UNPACK: begin
          am <= {|a[30:23], a[22:0]};
          bm <= {|b[30:23], b[22:0]};
          ae <= ~|a[30:23] ? 10'(EMIN) : 10'(int'(a[30:23]) - EXP_BIAS);
          be <= ~|b[30:23] ? 10'(EMIN) : 10'(int'(b[30:23]) - EXP_BIAS);
        end
        SPECIAL: begin
          output_z <= nan_case ? QNAN : (a_inf | b_inf) ? (POS_INF | {sz, 31'b0}) :
                      (a_zero | b_zero) ? {sz, 31'b0} : output_z;
          output_z_stb <= special;
        end
        NORM_A: if (!am[23]) begin
          am <= am << 1;
          ae <= ae - 10'sd1;
        end
        NORM_B: if (!bm[23]) begin
          bm <= bm << 1;
          be <= be - 10'sd1;
        end
        MUL0: begin
          s <= sz;
          e <= ae + be + 10'sd1;
          prod <= {24'b0, am} * {24'b0, bm};
        end
        MUL1: begin
          m <= prod[47:24];
          g <= prod[23];
          r <= prod[22];
          st <= |prod[21:0];
        end
        NORM1: if (!m[23] && e > EMIN) begin
          m <= {m[22:0], g};
          g <= r;
          r <= 1'b0;
          e <= e - 10'sd1;
        end
        NORM2: if (e < EMIN) begin
          m <= m >> 1;
          g <= m[0];
          r <= g;
          st <= st | r;
          e <= e + 10'sd1;
        end
        ROUND: if (g & (r | st | m[0])) begin
          m <= &m ? 24'h800000 : m + 24'd1;
          if (&m) e <= e + 10'sd1;
        end
        PACK: begin
          output_z <= (e > EXP_BIAS) ? {s, 8'hff, 23'b0} :
                      (e == EMIN && !m[23]) ? {s, 8'h00, m[22:0]} :
                      {s, 8'(e + EXP_BIAS), m[22:0]};
          output_z_stb <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_multiplier_no_handshake.sv
// tb_fpu_multiplier_no_handshake: directed vectors with hand-computed products and control checks
module tb_fpu_multiplier_no_handshake;
  logic clk = 0, rst = 1;
  logic [31:0] input_a = 0, input_b = 0, output_z;
  logic input_a_stb = 0, input_b_stb = 0, output_z_stb;
  int checks = 0, failures = 0, pulses;
  logic [31:0] got;
  fpu_multiplier_no_handshake dut (
    .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb),
    .input_b(input_b), .input_b_stb(input_b_stb), .output_z(output_z), .output_z_stb(output_z_stb)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [31:0] a, input logic [31:0] b, input int hold);
    @(negedge clk);
    input_a = a;
    input_b = b;
    input_a_stb = 1;
    input_b_stb = 1;
    repeat (hold) @(negedge clk);
    input_a_stb = 0;
    input_b_stb = 0;
  endtask
  task automatic watch(input int cycles);
    pulses = 0;
    got = 32'hDEADBEEF;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) begin
        pulses++;
        got = output_z;
      end
    end
  endtask
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int hold);
    strobe(a, b, hold);
    watch(80);
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_z"}, got, exp);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_z", output_z, 32'h0);
    chk("reset_stb", {31'b0, output_z_stb}, 32'h0);
    @(negedge clk);
    rst = 0;
    op("one_x_two", 32'h3F800000, 32'h40000000, 32'h40000000, 1);
    op("three_x_four", 32'h40400000, 32'h40800000, 32'h41400000, 1);
    op("pi_x_m2p5", 32'h40490FDB, 32'hC0200000, 32'hC0FB53D2, 1);
    strobe(32'h00000000, 32'h3F800000, 1);
    @(posedge clk); #1;
    chk("zero_lat_e2", {31'b0, output_z_stb}, 32'h0);
    @(posedge clk); #1;
    chk("zero_lat_e3", {31'b0, output_z_stb}, 32'h1);
    chk("zero_z", output_z, 32'h0);
    @(posedge clk); #1;
    chk("zero_stb_one_cycle", {31'b0, output_z_stb}, 32'h0);
    op("ninf_x_zero", 32'hFF800000, 32'h00000000, 32'h7FC00000, 1);
    op("inf_x_one", 32'h7F800000, 32'h3F800000, 32'h7F800000, 1);
    op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 1);
    op("held_strobes", 32'h40400000, 32'h40800000, 32'h41400000, 6);
    strobe(32'h3F800000, 32'h40000000, 1);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    watch(40);
    chk("reset_mid_pulses", 32'(pulses), 32'd0);
    chk("reset_mid_z", output_z, 32'h0);
    op("denormal", 32'h00000001, 32'h4B000000, 32'h00800000, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
